// File: rtl/vpg_mode_ctrl_pkg.sv
// Shared types and the constant video timing table for the VGA mode controller.
// Timing words are 0-based counter values: *_total is the last count of a line/frame,
// *_sync the last count of the sync pulse, *_start/*_end bound the active region.
package vpg_timing_pkg;

    localparam int TIMING_W = 12;
    localparam int CNT_W    = 24;

    typedef logic [TIMING_W-1:0] timing_word_t;
    typedef logic [CNT_W-1:0]    cnt_t;

    typedef enum logic [1:0] {
        MODE_640X480   = 2'd0,
        MODE_800X600   = 2'd1,
        MODE_1280X720  = 2'd2,
        MODE_1920X1080 = 2'd3
    } vpg_mode_e;

    typedef struct packed {
        timing_word_t h_total;
        timing_word_t h_sync;
        timing_word_t h_start;
        timing_word_t h_end;
        timing_word_t v_total;
        timing_word_t v_sync;
        timing_word_t v_start;
        timing_word_t v_end;
        timing_word_t v_active_14;
        timing_word_t v_active_24;
        timing_word_t v_active_34;
    } vpg_timing_t;

    typedef enum logic [3:0] {
        ST_INIT     = 4'd0,
        ST_IDLE     = 4'd1,
        ST_WAIT_VS  = 4'd2,
        ST_HOLD     = 4'd3,
        ST_PLL_CFG  = 4'd4,
        ST_PLL_WAIT = 4'd5,
        ST_LOAD     = 4'd6,
        ST_SETTLE   = 4'd7,
        ST_RELEASE  = 4'd8
    } vpg_state_e;

    // Timing set per mode; v_active_k4 = v_start + k * active_lines / 4.
    function automatic vpg_timing_t vpg_timing(input vpg_mode_e mode);
        vpg_timing_t t;
        case (mode)
            MODE_800X600:   t = '{12'd1055, 12'd127, 12'd215, 12'd1015,
                                  12'd627,  12'd3,   12'd26,  12'd626,
                                  12'd176,  12'd326, 12'd476};
            MODE_1280X720:  t = '{12'd1649, 12'd39,  12'd259, 12'd1539,
                                  12'd749,  12'd4,   12'd24,  12'd744,
                                  12'd204,  12'd384, 12'd564};
            MODE_1920X1080: t = '{12'd2199, 12'd43,  12'd191, 12'd2111,
                                  12'd1124, 12'd4,   12'd40,  12'd1120,
                                  12'd310,  12'd580, 12'd850};
            default:        t = '{12'd799,  12'd95,  12'd143, 12'd783,
                                  12'd524,  12'd1,   12'd34,  12'd514,
                                  12'd154,  12'd274, 12'd394};
        endcase
        return t;
    endfunction

    // Down-counter reload value so that a state lasts exactly 'cycles' clocks.
    function automatic cnt_t cnt_load(input cnt_t cycles);
        return (cycles == '0) ? '0 : cycles - cnt_t'(1);
    endfunction

endpackage

// File: rtl/vpg_mode_ctrl_if.sv
// Host-side mode request handshake of the VGA mode controller.
// The host (master) holds mode_req high until it sees mode_ack.
interface vpg_mode_ctrl_if;
    logic       mode_req;
    logic [1:0] mode_sel;
    logic       mode_ack;
    logic       busy;
    logic [1:0] cur_mode;
    logic       cfg_error;

    modport master (
        output mode_req, mode_sel,
        input  mode_ack, busy, cur_mode, cfg_error
    );

    modport slave (
        input  mode_req, mode_sel,
        output mode_ack, busy, cur_mode, cfg_error
    );
endinterface

// File: rtl/vpg_mode_ctrl_timing_rom.sv
// Registered timing lookup: the output register drives the generator timing
// ports directly, so the whole set changes on a single edge when enabled.
module vpg_timing_rom
    import vpg_timing_pkg::*;
#(
    parameter logic [1:0] DEFAULT_MODE = 2'd0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en_i,
    input  vpg_mode_e   mode_i,
    output vpg_timing_t timing_o
);

    vpg_timing_t timing_q;

    // Load the selected row when enabled, otherwise hold the applied timing.
    // NOTE: the table itself is constant logic and needs no reset; only this
    // output register is reset, so the generator sees a valid row from reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timing_q <= vpg_timing(vpg_mode_e'(DEFAULT_MODE));
        end else if (en_i) begin
            timing_q <= vpg_timing(mode_i);
        end
    end

    assign timing_o = timing_q;

endmodule

// File: rtl/vpg_mode_ctrl.sv
// Video mode-change sequencer: waits for a frame boundary, holds the timing
// generator in reset, reprograms the pixel PLL, loads the new timing set and
// releases the generator. DEFAULT_MODE is configured automatically after reset.
module vpg_mode_ctrl
    import vpg_timing_pkg::*;
#(
    parameter logic [1:0]  DEFAULT_MODE  = 2'd0,
    parameter logic [23:0] VS_TIMEOUT    = 24'd2000000,
    parameter logic [23:0] PLL_TIMEOUT   = 24'd1000000,
    parameter logic [23:0] SETTLE_CYCLES = 24'd16
) (
    input  logic         clk,
    input  logic         reset_n,
    vpg_mode_ctrl_if.slave host,
    input  logic         vga_vs_i,
    output logic         pll_start_o,
    output logic [1:0]   pll_mode_o,
    input  logic         pll_done_i,
    input  logic         pll_locked_i,
    output logic         gen_reset_n_o,
    output logic [11:0]  h_total_o,
    output logic [11:0]  h_sync_o,
    output logic [11:0]  h_start_o,
    output logic [11:0]  h_end_o,
    output logic [11:0]  v_total_o,
    output logic [11:0]  v_sync_o,
    output logic [11:0]  v_start_o,
    output logic [11:0]  v_end_o,
    output logic [11:0]  v_active_14_o,
    output logic [11:0]  v_active_24_o,
    output logic [11:0]  v_active_34_o
);

    localparam vpg_mode_e DEF_MODE    = vpg_mode_e'(DEFAULT_MODE);
    localparam cnt_t      VS_LOAD     = cnt_load(VS_TIMEOUT);
    localparam cnt_t      PLL_LOAD    = cnt_load(PLL_TIMEOUT);
    localparam cnt_t      SETTLE_LOAD = cnt_load(SETTLE_CYCLES);

    vpg_state_e  state_q;
    cnt_t        cnt_q;
    vpg_mode_e   target_q;
    vpg_mode_e   cur_mode_q;
    vpg_mode_e   pll_mode_q;
    logic        pll_start_q;
    logic        mode_ack_q;
    logic        busy_q;
    logic        cfg_error_q;
    logic        gen_reset_n_q;
    logic        req_pending_q;
    logic        done_seen_q;

    logic        vs_meta_q, vs_sync_q, vs_prev_q;
    logic        lock_meta_q, lock_sync_q;
    logic        vs_fall;
    logic        cnt_expired;
    vpg_timing_t timing;

    // Two-flop synchronisers for the pixel-domain vsync and the PLL lock, plus
    // one extra vsync stage for falling-edge detection (vsync is active low).
    // NOTE: every register here uses <=, so all stages sample the values from
    // before the edge; blocking '=' would collapse the chain into one flop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vs_meta_q   <= 1'b1;
            vs_sync_q   <= 1'b1;
            vs_prev_q   <= 1'b1;
            lock_meta_q <= 1'b0;
            lock_sync_q <= 1'b0;
        end else begin
            vs_meta_q   <= vga_vs_i;
            vs_sync_q   <= vs_meta_q;
            vs_prev_q   <= vs_sync_q;
            lock_meta_q <= pll_locked_i;
            lock_sync_q <= lock_meta_q;
        end
    end

    assign vs_fall     = vs_prev_q & ~vs_sync_q;
    assign cnt_expired = (cnt_q == '0);

    // Mode-change sequencer; the shared down-counter is reloaded on each state entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_INIT;
            cnt_q         <= '0;
            target_q      <= DEF_MODE;
            cur_mode_q    <= DEF_MODE;
            pll_mode_q    <= DEF_MODE;
            pll_start_q   <= 1'b0;
            mode_ack_q    <= 1'b0;
            busy_q        <= 1'b1;
            cfg_error_q   <= 1'b0;
            gen_reset_n_q <= 1'b0;
            req_pending_q <= 1'b0;
            done_seen_q   <= 1'b0;
        end else begin
            mode_ack_q  <= 1'b0;
            pll_start_q <= 1'b0;
            if (!cnt_expired) begin
                cnt_q <= cnt_q - cnt_t'(1);
            end
            // A host that withdraws its request mid-sequence gets no ack.
            if (state_q != ST_IDLE && !host.mode_req) begin
                req_pending_q <= 1'b0;
            end

            case (state_q)
                ST_INIT: begin
                    target_q      <= DEF_MODE;
                    req_pending_q <= 1'b0;
                    cnt_q         <= '0;
                    state_q       <= ST_PLL_CFG;
                end
                ST_IDLE: begin
                    // The ack cycle itself is skipped so a host still holding
                    // mode_req while it sees the ack is not acknowledged twice.
                    if (host.mode_req && !mode_ack_q) begin
                        if (host.mode_sel == cur_mode_q) begin
                            mode_ack_q <= 1'b1;
                        end else begin
                            target_q      <= vpg_mode_e'(host.mode_sel);
                            cfg_error_q   <= 1'b0;
                            req_pending_q <= 1'b1;
                            busy_q        <= 1'b1;
                            cnt_q         <= VS_LOAD;
                            state_q       <= ST_WAIT_VS;
                        end
                    end
                end
                ST_WAIT_VS: begin
                    if (vs_fall || cnt_expired) begin
                        gen_reset_n_q <= 1'b0;
                        cnt_q         <= '0;
                        state_q       <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    cnt_q   <= '0;
                    state_q <= ST_PLL_CFG;
                end
                ST_PLL_CFG: begin
                    pll_mode_q  <= target_q;
                    pll_start_q <= 1'b1;
                    done_seen_q <= 1'b0;
                    cnt_q       <= PLL_LOAD;
                    state_q     <= ST_PLL_WAIT;
                end
                ST_PLL_WAIT: begin
                    if (pll_done_i) begin
                        done_seen_q <= 1'b1;
                    end
                    if ((done_seen_q || pll_done_i) && lock_sync_q) begin
                        cnt_q   <= '0;
                        state_q <= ST_LOAD;
                    end else if (cnt_expired) begin
                        cfg_error_q <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    cur_mode_q <= target_q;
                    cnt_q      <= SETTLE_LOAD;
                    state_q    <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (cnt_expired) begin
                        cnt_q   <= '0;
                        state_q <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    gen_reset_n_q <= 1'b1;
                    mode_ack_q    <= req_pending_q & host.mode_req;
                    req_pending_q <= 1'b0;
                    busy_q        <= 1'b0;
                    cnt_q         <= '0;
                    state_q       <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_INIT;
                end
            endcase
        end
    end

    vpg_timing_rom #(
        .DEFAULT_MODE(DEFAULT_MODE)
    ) u_timing_rom (
        .clk      (clk),
        .reset_n  (reset_n),
        .en_i     (state_q == ST_LOAD),
        .mode_i   (target_q),
        .timing_o (timing)
    );

    assign host.mode_ack  = mode_ack_q;
    assign host.busy      = busy_q;
    assign host.cur_mode  = cur_mode_q;
    assign host.cfg_error = cfg_error_q;

    assign pll_start_o   = pll_start_q;
    assign pll_mode_o    = pll_mode_q;
    assign gen_reset_n_o = gen_reset_n_q;

    assign h_total_o     = timing.h_total;
    assign h_sync_o      = timing.h_sync;
    assign h_start_o     = timing.h_start;
    assign h_end_o       = timing.h_end;
    assign v_total_o     = timing.v_total;
    assign v_sync_o      = timing.v_sync;
    assign v_start_o     = timing.v_start;
    assign v_end_o       = timing.v_end;
    assign v_active_14_o = timing.v_active_14;
    assign v_active_24_o = timing.v_active_24;
    assign v_active_34_o = timing.v_active_34;

endmodule

// File: tb/tb_vpg_mode_ctrl.sv
// Self-checking bench for vpg_mode_ctrl: a table of mode requests with
// hand-computed timing rows, plus directed sequences for the corner cases.
module tb_vpg_mode_ctrl;

    localparam logic [23:0] VS_TO  = 24'd300;
    localparam logic [23:0] PLL_TO = 24'd200;
    localparam logic [23:0] SETTLE = 24'd16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        vga_vs = 1'b1;
    logic        pll_done = 1'b0;
    logic        pll_locked = 1'b0;
    logic        pll_start;
    logic [1:0]  pll_mode;
    logic        gen_reset_n;
    logic [11:0] h_total, h_sync, h_start, h_end;
    logic [11:0] v_total, v_sync, v_start, v_end;
    logic [11:0] v_a14, v_a24, v_a34;

    vpg_mode_ctrl_if host_if();

    vpg_mode_ctrl #(
        .DEFAULT_MODE (2'd0),
        .VS_TIMEOUT   (VS_TO),
        .PLL_TIMEOUT  (PLL_TO),
        .SETTLE_CYCLES(SETTLE)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .host         (host_if),
        .vga_vs_i     (vga_vs),
        .pll_start_o  (pll_start),
        .pll_mode_o   (pll_mode),
        .pll_done_i   (pll_done),
        .pll_locked_i (pll_locked),
        .gen_reset_n_o(gen_reset_n),
        .h_total_o    (h_total),
        .h_sync_o     (h_sync),
        .h_start_o    (h_start),
        .h_end_o      (h_end),
        .v_total_o    (v_total),
        .v_sync_o     (v_sync),
        .v_start_o    (v_start),
        .v_end_o      (v_end),
        .v_active_14_o(v_a14),
        .v_active_24_o(v_a24),
        .v_active_34_o(v_a34)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // ---------------- environment models ----------------
    bit vs_run = 1'b0;
    bit vs_fell = 1'b0;
    bit pll_respond = 1'b1;
    int pll_delay = 50;

    // vsync: 60-cycle frame, 4-cycle low pulse; held high when stopped.
    initial begin
        int phase = 0;
        forever begin
            @(posedge clk); #1;
            if (vs_run) begin
                phase++;
                if (phase >= 60) begin
                    phase = 0;
                    vga_vs = 1'b0;
                    vs_fell = 1'b1;
                end else if (phase == 4) begin
                    vga_vs = 1'b1;
                end
            end else begin
                vga_vs = 1'b1;
            end
        end
    end

    // PLL reconfig block: loses lock on start, relocks and pulses done later.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (pll_start) begin
                pll_locked = 1'b0;
                if (pll_respond) begin
                    repeat (pll_delay) @(posedge clk);
                    #1;
                    pll_locked = 1'b1;
                    pll_done   = 1'b1;
                    @(posedge clk); #1;
                    pll_done   = 1'b0;
                end
            end
        end
    end

    // Monitor: ack pulse count and timing stability while the generator runs.
    int ack_count = 0;
    int viol = 0;
    logic [131:0] tim_now, tim_prev;
    assign tim_now = {h_total, h_sync, h_start, h_end, v_total, v_sync,
                      v_start, v_end, v_a14, v_a24, v_a34};
    initial begin
        tim_prev = tim_now;
        forever begin
            @(negedge clk);
            ack_count += int'(host_if.mode_ack);
            if (reset_n && gen_reset_n === 1'b1 && tim_now !== tim_prev) viol++;
            tim_prev = tim_now;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    function automatic logic sig(input int which);
        case (which)
            0:       return gen_reset_n;
            1:       return host_if.busy;
            2:       return host_if.mode_ack;
            3:       return pll_start;
            default: return pll_done;
        endcase
    endfunction

    // Waits at negedges for a signal level; a timeout is a failed comparison.
    task automatic wait_sig(input int which, input logic level, input int budget,
                            input string name, output int n);
        n = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sig(which) === level) begin
                n = i + 1;
                break;
            end
        end
        if (n < 0) begin
            total++;
            bad++;
            $display("FAIL %s: level %0d not seen within %0d cycles", name, level, budget);
        end
    endtask

    typedef struct packed {
        logic [1:0]        sel;
        logic [10:0][11:0] exp;
    } vec_t;

    vec_t vecs[4];
    string fname[11] = '{"h_total", "h_sync", "h_start", "h_end", "v_total", "v_sync",
                         "v_start", "v_end", "v_active_14", "v_active_24", "v_active_34"};

    function automatic vec_t mk(input logic [1:0] s, input int a, b, c, d, e, f,
                                input int g, h, i, j, k);
        vec_t v;
        v.sel = s;
        v.exp[0] = 12'(a);  v.exp[1] = 12'(b);  v.exp[2] = 12'(c);  v.exp[3] = 12'(d);
        v.exp[4] = 12'(e);  v.exp[5] = 12'(f);  v.exp[6] = 12'(g);  v.exp[7] = 12'(h);
        v.exp[8] = 12'(i);  v.exp[9] = 12'(j);  v.exp[10] = 12'(k);
        return v;
    endfunction

    function automatic logic [10:0][11:0] tim_arr();
        logic [10:0][11:0] t;
        t[0] = h_total; t[1] = h_sync;  t[2] = h_start; t[3] = h_end;
        t[4] = v_total; t[5] = v_sync;  t[6] = v_start; t[7] = v_end;
        t[8] = v_a14;   t[9] = v_a24;   t[10] = v_a34;
        return t;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int n, t0, a0, busy_seen;
        logic [10:0][11:0] act;

        vecs[0] = mk(2'd2, 1649, 39, 259, 1539, 749, 4, 24, 744, 204, 384, 564);
        vecs[1] = mk(2'd1, 1055, 127, 215, 1015, 627, 3, 26, 626, 176, 326, 476);
        vecs[2] = mk(2'd3, 2199, 43, 191, 2111, 1124, 4, 40, 1120, 310, 580, 850);
        vecs[3] = mk(2'd0, 799, 95, 143, 783, 524, 1, 34, 514, 154, 274, 394);

        host_if.mode_req = 1'b0;
        host_if.mode_sel = 2'd0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_gen_reset_n", gen_reset_n, 0);
        check("rst_busy", host_if.busy, 1);
        check("rst_mode_ack", host_if.mode_ack, 0);
        check("rst_pll_start", pll_start, 0);
        check("rst_cfg_error", host_if.cfg_error, 0);
        check("rst_cur_mode", host_if.cur_mode, 0);
        check("rst_h_total", h_total, 799);
        check("rst_v_active_34", v_a34, 394);

        // 1: power-up configuration of the default mode
        reset_n = 1'b1;
        wait_sig(4, 1'b1, 200, "t1_pll_done", n);
        t0 = cyc;
        wait_sig(0, 1'b1, 200, "t1_gen_release", n);
        check_range("t1_release_latency", cyc - t0, int'(SETTLE) + 2, int'(SETTLE) + 8);
        check("t1_h_total", h_total, 799);
        check("t1_v_end", v_end, 514);
        check("t1_cur_mode", host_if.cur_mode, 0);
        check("t1_pll_mode", pll_mode, 0);
        check("t1_busy", host_if.busy, 0);
        repeat (3) @(negedge clk);
        check("t1_no_ack", ack_count, 0);

        // 2: table of mode changes with vsync running
        vs_run = 1'b1;
        pll_delay = 20;
        for (int i = 0; i < 4; i++) begin
            a0 = ack_count;
            vs_fell = 1'b0;
            host_if.mode_sel = vecs[i].sel;
            host_if.mode_req = 1'b1;
            wait_sig(0, 1'b0, 200, "t2_gen_hold", n);
            check("t2_hold_after_vs_fall", vs_fell, 1);
            wait_sig(2, 1'b1, 600, "t2_ack", n);
            host_if.mode_req = 1'b0;
            check("t2_pll_mode", pll_mode, vecs[i].sel);
            check("t2_cur_mode", host_if.cur_mode, vecs[i].sel);
            check("t2_gen_reset_n", gen_reset_n, 1);
            act = tim_arr();
            for (int f = 0; f < 11; f++) begin
                check($sformatf("t2_mode%0d_%s", vecs[i].sel, fname[f]), act[f], vecs[i].exp[f]);
            end
            repeat (4) @(negedge clk);
            check("t2_single_ack", ack_count - a0, 1);
            check("t2_busy_idle", host_if.busy, 0);
        end

        // 3: same-mode request is acked the next cycle without disturbance
        a0 = ack_count;
        host_if.mode_sel = 2'd0;
        host_if.mode_req = 1'b1;
        @(negedge clk);
        check("t3_ack_next_cycle", host_if.mode_ack, 1);
        host_if.mode_req = 1'b0;
        busy_seen = 0;
        for (int i = 0; i < 5; i++) begin
            busy_seen += int'(host_if.busy) + int'(!gen_reset_n);
            @(negedge clk);
        end
        check("t3_no_disturbance", busy_seen, 0);
        check("t3_single_ack", ack_count - a0, 1);

        // 4: PLL never completes -> cfg_error, timing still loaded, ack still issued
        pll_respond = 1'b0;
        host_if.mode_sel = 2'd1;
        host_if.mode_req = 1'b1;
        wait_sig(2, 1'b1, 1000, "t4_ack", n);
        host_if.mode_req = 1'b0;
        check("t4_cfg_error", host_if.cfg_error, 1);
        check("t4_h_total", h_total, 1055);
        check("t4_v_total", v_total, 627);
        check("t4_cur_mode", host_if.cur_mode, 1);
        repeat (2) @(negedge clk);
        check("t4_cfg_error_sticky", host_if.cfg_error, 1);
        pll_respond = 1'b1;
        host_if.mode_sel = 2'd3;
        host_if.mode_req = 1'b1;
        wait_sig(1, 1'b1, 5, "t4_accept", n);
        check("t4_cfg_error_cleared", host_if.cfg_error, 0);
        wait_sig(2, 1'b1, 600, "t4_ack2", n);
        host_if.mode_req = 1'b0;
        check("t4_cfg_error_after", host_if.cfg_error, 0);
        check("t4_h_total_mode3", h_total, 2199);

        // 5: vsync stuck high -> forced switch after VS_TIMEOUT; mode_sel changes while busy ignored
        vs_run = 1'b0;
        @(negedge clk);
        host_if.mode_sel = 2'd2;
        host_if.mode_req = 1'b1;
        wait_sig(1, 1'b1, 5, "t5_accept", n);
        t0 = cyc;
        host_if.mode_sel = 2'd1;
        wait_sig(0, 1'b0, int'(VS_TO) + 50, "t5_forced_hold", n);
        check_range("t5_vs_timeout", cyc - t0, int'(VS_TO) - 2, int'(VS_TO) + 3);
        wait_sig(2, 1'b1, 600, "t5_ack", n);
        host_if.mode_req = 1'b0;
        check("t5_cur_mode", host_if.cur_mode, 2);
        check("t5_h_total", h_total, 1649);
        check("t5_pll_mode", pll_mode, 2);
        busy_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            busy_seen += int'(host_if.busy);
        end
        check("t5_no_second_sequence", busy_seen, 0);

        // 5b: request withdrawn mid-sequence -> completes without ack
        a0 = ack_count;
        host_if.mode_sel = 2'd3;
        host_if.mode_req = 1'b1;
        wait_sig(1, 1'b1, 5, "t5b_accept", n);
        repeat (10) @(negedge clk);
        host_if.mode_req = 1'b0;
        wait_sig(1, 1'b0, 900, "t5b_done", n);
        repeat (3) @(negedge clk);
        check("t5b_no_ack", ack_count - a0, 0);
        check("t5b_cur_mode", host_if.cur_mode, 3);
        check("t5b_h_total", h_total, 2199);

        // 6: reset during PLL_WAIT -> reset values at once, then default mode reconfigured
        vs_run = 1'b1;
        pll_respond = 1'b0;
        a0 = ack_count;
        host_if.mode_sel = 2'd1;
        host_if.mode_req = 1'b1;
        wait_sig(3, 1'b1, 300, "t6_pll_start", n);
        repeat (5) @(negedge clk);
        check("t6_pll_mode_before", pll_mode, 1);
        reset_n = 1'b0;
        host_if.mode_req = 1'b0;
        #1;
        check("t6_gen_reset_n", gen_reset_n, 0);
        check("t6_busy", host_if.busy, 1);
        check("t6_cur_mode", host_if.cur_mode, 0);
        check("t6_pll_mode", pll_mode, 0);
        check("t6_h_total", h_total, 799);
        check("t6_v_end", v_end, 514);
        check("t6_mode_ack", host_if.mode_ack, 0);
        repeat (2) @(negedge clk);
        pll_respond = 1'b1;
        reset_n = 1'b1;
        wait_sig(3, 1'b1, 10, "t6_init_pll_start", n);
        check("t6_init_pll_mode", pll_mode, 0);
        wait_sig(0, 1'b1, 300, "t6_release", n);
        check("t6_cur_mode_after", host_if.cur_mode, 0);
        check("t6_h_total_after", h_total, 799);
        repeat (3) @(negedge clk);
        check("t6_no_ack", ack_count - a0, 0);

        check("timing_stable_while_running", viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
